// File: rtl/core_l1i.sv
// Direct-mapped L1 instruction cache, one 32-bit word per line.
// Single-outstanding refill over a word-wide request/response bus.
module core_l1i #(
   parameter int LINES = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        core_req_val,
   input  logic [31:0] core_req_addr,
   output logic        core_req_ack,
   input  logic        core_kill,
   input  logic        core_flush,
   output logic        core_resp_val,
   output logic [31:0] core_resp_data,
   output logic        mem_req_val,
   output logic [31:0] mem_req_addr,
   input  logic        mem_req_ack,
   input  logic        mem_resp_val,
   input  logic [31:0] mem_resp_data
);

   localparam int IDX = $clog2(LINES);
   localparam int TW  = 30 - IDX;

   typedef enum logic [1:0] {
      IDLE,
      MISS_REQ,
      MISS_WAIT
   } state_t;

   state_t            state_q, state_d;
   logic [LINES-1:0]  valid_q, valid_d;
   logic [TW-1:0]     tag_q  [LINES];
   logic [31:0]       data_q [LINES];
   logic [31:2]       addr_q, addr_d;
   logic              kill_q, kill_d;
   logic              resp_val_q, resp_val_d;
   logic [31:0]       resp_data_q, resp_data_d;
   logic              mreq_val_q, mreq_val_d;
   logic [31:0]       mreq_addr_q, mreq_addr_d;
   logic              fill_we;

   logic [IDX-1:0]    req_idx;
   logic [TW-1:0]     req_tag;
   logic [IDX-1:0]    fill_idx;
   logic [TW-1:0]     fill_tag;
   logic              hit;
   logic              unused_addr_lsb;

   assign req_idx  = core_req_addr[IDX+1:2];
   assign req_tag  = core_req_addr[31:IDX+2];
   assign fill_idx = addr_q[IDX+1:2];
   assign fill_tag = addr_q[31:IDX+2];
   assign unused_addr_lsb = ^core_req_addr[1:0];

   // A flush in the lookup cycle forces a miss.
   assign hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag)
                && !core_flush;

   assign core_req_ack   = (state_q == IDLE);
   assign core_resp_val  = resp_val_q;
   assign core_resp_data = resp_data_q;
   assign mem_req_val    = mreq_val_q;
   assign mem_req_addr   = mreq_addr_q;

   always_comb begin
      state_d     = state_q;
      valid_d     = valid_q;
      addr_d      = addr_q;
      kill_d      = kill_q;
      resp_val_d  = 1'b0;
      resp_data_d = resp_data_q;
      mreq_val_d  = mreq_val_q;
      mreq_addr_d = mreq_addr_q;
      fill_we     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (core_req_val) begin
               if (hit) begin
                  resp_val_d  = 1'b1;
                  resp_data_d = data_q[req_idx];
               end else begin
                  addr_d      = core_req_addr[31:2];
                  kill_d      = 1'b0;
                  mreq_val_d  = 1'b1;
                  mreq_addr_d = {core_req_addr[31:2], 2'b00};
                  state_d     = MISS_REQ;
               end
            end
         end
         MISS_REQ: begin
            if (core_kill) kill_d = 1'b1;
            if (mem_req_ack) begin
               mreq_val_d = 1'b0;
               state_d    = MISS_WAIT;
            end
         end
         MISS_WAIT: begin
            if (core_kill) kill_d = 1'b1;
            if (mem_resp_val) begin
               fill_we           = 1'b1;
               valid_d[fill_idx] = 1'b1;
               state_d           = IDLE;
               if (!(kill_q || core_kill)) begin
                  resp_val_d  = 1'b1;
                  resp_data_d = mem_resp_data;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (core_flush) valid_d = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         valid_q     <= '0;
         addr_q      <= '0;
         kill_q      <= 1'b0;
         resp_val_q  <= 1'b0;
         resp_data_q <= '0;
         mreq_val_q  <= 1'b0;
         mreq_addr_q <= '0;
      end else begin
         state_q     <= state_d;
         valid_q     <= valid_d;
         addr_q      <= addr_d;
         kill_q      <= kill_d;
         resp_val_q  <= resp_val_d;
         resp_data_q <= resp_data_d;
         mreq_val_q  <= mreq_val_d;
         mreq_addr_q <= mreq_addr_d;
      end
   end

   // Tag/data need no reset; the valid bits gate them.
   always_ff @(posedge clk) begin
      if (fill_we) begin
         tag_q[fill_idx]  <= fill_tag;
         data_q[fill_idx] <= mem_resp_data;
      end
   end

endmodule
